// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and overflow helper for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_FWD = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_e;

  // Operation carried out by the iterative unit.
  typedef enum logic [2:0] {ItSll, ItSrl, ItSra, ItRor, ItMul} iter_op_e;

  // Signed overflow from operand/result sign bits; B is inverted for subtraction.
  function automatic logic signed_ovf(input logic a_s, input logic b_s, input logic r_s,
                                      input logic is_sub);
    logic b_eff;
    b_eff = b_s ^ is_sub;
    return (a_s == b_eff) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift/rotate/multiply datapath: one bit position or multiplier bit per clock.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Width) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  iter_op_e         op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [CntW-1:0]  cnt_i,
  output logic [Width-1:0] result_o,
  output logic             last_o
);

  iter_op_e         op_q, op_d;
  logic [Width-1:0] work_q, work_d;
  logic [Width-1:0] mplier_q, mplier_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [Width-1:0] work_step;
  logic [Width-1:0] acc_step;

  // Value of the working registers after the step taken at the coming edge.
  always_comb begin
    work_step = work_q;
    acc_step  = acc_q + (mplier_q[0] ? work_q : '0);
    case (op_q)
      ItSll:   work_step = {work_q[Width-2:0], 1'b0};
      ItSrl:   work_step = {1'b0, work_q[Width-1:1]};
      ItSra:   work_step = {work_q[Width-1], work_q[Width-1:1]};
      ItRor:   work_step = {work_q[0], work_q[Width-1:1]};
      ItMul:   work_step = {work_q[Width-2:0], 1'b0};
      default: work_step = work_q;
    endcase
    result_o = (op_q == ItMul) ? acc_step : work_step;
    last_o   = (cnt_q == CntW'(1));
  end

  // Load on strobe, otherwise step while the counter is non-zero.
  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      op_d     = op_i;
      work_d   = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = cnt_i;
    end else if (cnt_q != '0) begin
      work_d   = work_step;
      mplier_d = {1'b0, mplier_q[Width-1:1]};
      acc_d    = acc_step;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  // Datapath state registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= ItSll;
      work_q   <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops and registered outputs.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             OVERFLOW
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW + 1;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [ShW-1:0]   sh_amt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] single_res;
  logic             single_ovf;
  logic             it_shift;
  logic             is_mul;
  iter_op_e         it_op;
  logic             iter_load;
  logic [CntW-1:0]  iter_cnt;
  logic [WIDTH-1:0] iter_res;
  logic             iter_last;

  // Decode the opcode: single-cycle result, or which iterative operation to launch.
  always_comb begin
    sh_amt     = DATA2[ShW-1:0];
    sum        = DATA1 + DATA2;
    diff       = DATA1 - DATA2;
    single_res = '0;
    single_ovf = 1'b0;
    it_shift   = 1'b0;
    it_op      = ItSll;
    case (SELECT)
      OP_FWD: single_res = DATA2;
      OP_ADD: begin
        single_res = sum;
        single_ovf = signed_ovf(DATA1[WIDTH-1], DATA2[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_AND: single_res = DATA1 & DATA2;
      OP_OR:  single_res = DATA1 | DATA2;
      OP_SUB: begin
        single_res = diff;
        single_ovf = signed_ovf(DATA1[WIDTH-1], DATA2[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      // A zero shift amount completes at once with DATA1 unchanged.
      OP_SLL: begin single_res = DATA1; it_op = ItSll; it_shift = (sh_amt != '0); end
      OP_SRL: begin single_res = DATA1; it_op = ItSrl; it_shift = (sh_amt != '0); end
      OP_SRA: begin single_res = DATA1; it_op = ItSra; it_shift = (sh_amt != '0); end
      OP_ROR: begin single_res = DATA1; it_op = ItRor; it_shift = (sh_amt != '0); end
      OP_MUL: it_op = ItMul;
      default: ;
    endcase
    is_mul    = (SELECT == OP_MUL) && MUL_EN;
    iter_load = (state_q == IDLE) && START && (it_shift || is_mul);
    iter_cnt  = is_mul ? CntW'(WIDTH) : CntW'(sh_amt);
  end

  alu_iter_unit #(
    .Width (WIDTH),
    .CntW  (CntW)
  ) u_iter (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .load_i   (iter_load),
    .op_i     (it_op),
    .a_i      (DATA1),
    .b_i      (DATA2),
    .cnt_i    (iter_cnt),
    .result_o (iter_res),
    .last_o   (iter_last)
  );

  // Handshake FSM and next value of the held outputs.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (is_mul) begin
            state_d = MUL;
            busy_d  = 1'b1;
          end else if (it_shift) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            ovf_d    = single_ovf;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT, MUL: begin
        if (iter_last) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign ZERO     = zero_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: 8-bit, 8-bit without MUL, and 16-bit instances.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic        start8 = 1'b0, start8n = 1'b0, start16 = 1'b0;
  logic [7:0]  d1_8 = '0, d2_8 = '0;
  logic [15:0] d1_16 = '0, d2_16 = '0;

  logic        busy8, done8, zero8, ovf8;
  logic [7:0]  res8;
  logic        busy8n, done8n, zero8n, ovf8n;
  logic [7:0]  res8n;
  logic        busy16, done16, zero16, ovf16;
  logic [15:0] res16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .CLK(clk), .RESET(rst), .START(start8), .SELECT(sel), .DATA1(d1_8), .DATA2(d2_8),
    .BUSY(busy8), .DONE(done8), .RESULT(res8), .ZERO(zero8), .OVERFLOW(ovf8)
  );

  alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) dut8n (
    .CLK(clk), .RESET(rst), .START(start8n), .SELECT(sel), .DATA1(d1_8), .DATA2(d2_8),
    .BUSY(busy8n), .DONE(done8n), .RESULT(res8n), .ZERO(zero8n), .OVERFLOW(ovf8n)
  );

  alu_mc #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
    .CLK(clk), .RESET(rst), .START(start16), .SELECT(sel), .DATA1(d1_16), .DATA2(d2_16),
    .BUSY(busy16), .DONE(done16), .RESULT(res16), .ZERO(zero16), .OVERFLOW(ovf16)
  );

  // Reference model from the opcode definitions using wide integer arithmetic.
  function automatic void model(input int w, input bit men, input logic [3:0] op,
                                input longint a, input longint b,
                                output longint r, output bit ov, output int lat);
    longint mask, half, sa, sb, t;
    int n;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    n    = int'(b % w);
    sa   = (a >= half) ? a - (mask + 1) : a;
    sb   = (b >= half) ? b - (mask + 1) : b;
    r    = 0;
    ov   = 1'b0;
    lat  = 0;
    case (op)
      4'h0: r = b;
      4'h1: begin r = (a + b) & mask; t = sa + sb; ov = (t >= half) || (t < -half); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: begin r = (a - b) & mask; t = sa - sb; ov = (t >= half) || (t < -half); end
      4'h5: begin r = (a << n) & mask; lat = n; end
      4'h6: begin r = a >> n; lat = n; end
      4'h7: begin r = (sa >>> n) & mask; lat = n; end
      4'h8: begin r = ((a >> n) | (a << (w - n))) & mask; lat = n; end
      4'h9: if (men) begin r = (a * b) & mask; lat = w; end
      default: r = 0;
    endcase
  endfunction

  function automatic logic cur_done(input int u);
    return (u == 0) ? done8 : (u == 1) ? done8n : done16;
  endfunction
  function automatic logic cur_busy(input int u);
    return (u == 0) ? busy8 : (u == 1) ? busy8n : busy16;
  endfunction
  function automatic logic [15:0] cur_res(input int u);
    return (u == 0) ? {8'h00, res8} : (u == 1) ? {8'h00, res8n} : res16;
  endfunction
  function automatic logic cur_zero(input int u);
    return (u == 0) ? zero8 : (u == 1) ? zero8n : zero16;
  endfunction
  function automatic logic cur_ovf(input int u);
    return (u == 0) ? ovf8 : (u == 1) ? ovf8n : ovf16;
  endfunction

  task automatic set_start(input int u, input logic v);
    case (u)
      0: start8 = v;
      1: start8n = v;
      default: start16 = v;
    endcase
  endtask

  task automatic drive_ops(input int u, input logic [15:0] a, input logic [15:0] b);
    if (u == 2) begin
      d1_16 = a;
      d2_16 = b;
    end else begin
      d1_8 = a[7:0];
      d2_8 = b[7:0];
    end
  endtask

  // Issue one operation, scramble inputs after accept, observe latency and handshake.
  task automatic issue(input int u, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int lat, output bit busy_ok,
                       output bit pulse_ok, output logic [15:0] res, output logic z,
                       output logic ov);
    logic [31:0] rnd;
    @(negedge clk);
    sel = op;
    drive_ops(u, a, b);
    set_start(u, 1'b1);
    @(posedge clk);
    #1;
    set_start(u, 1'b0);
    rnd = $urandom;
    sel = rnd[3:0];
    drive_ops(u, rnd[15:0], rnd[31:16]);
    lat = 0;
    busy_ok = 1'b1;
    while (cur_done(u) !== 1'b1 && lat < 40) begin
      if (cur_busy(u) !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (cur_busy(u) !== 1'b0) busy_ok = 1'b0;
    res = cur_res(u);
    z   = cur_zero(u);
    ov  = cur_ovf(u);
    @(posedge clk);
    #1;
    pulse_ok = (cur_done(u) === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      tests_run++;
      if ({cur_busy(u), cur_done(u), cur_res(u), cur_zero(u), cur_ovf(u)} !== 20'h0) begin
        tests_failed++;
        $display("FAIL reset_values unit=%0d got busy=%b done=%b res=%h zero=%b ovf=%b want all 0",
                 u, cur_busy(u), cur_done(u), cur_res(u), cur_zero(u), cur_ovf(u));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy8, done8, res8, zero8, ovf8} !== 12'h0) begin
      tests_failed++;
      $display("FAIL idle_after_reset got busy=%b done=%b res=%h want 0/0/00",
               busy8, done8, res8);
    end
  endtask

  // Worked vectors on the 8-bit instance with hand-computed expectations.
  task automatic test_directed();
    logic [3:0]  ops [7]  = '{4'h1, 4'h4, 4'hF, 4'h7, 4'h8, 4'h5, 4'h9};
    logic [15:0] as  [7]  = '{16'h7F, 16'h05, 16'h33, 16'h90, 16'h81, 16'h81, 16'h0D};
    logic [15:0] bs  [7]  = '{16'h01, 16'h05, 16'h44, 16'h03, 16'h01, 16'h00, 16'h0B};
    logic [15:0] er  [7]  = '{16'h80, 16'h00, 16'h00, 16'hF2, 16'hC0, 16'h81, 16'h8F};
    logic        eo  [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          el  [7]  = '{0, 0, 0, 3, 1, 0, 8};
    int lat;
    bit bok, pok;
    logic [15:0] res;
    logic z, ov;
    for (int i = 0; i < 7; i++) begin
      issue(0, ops[i], as[i], bs[i], lat, bok, pok, res, z, ov);
      tests_run++;
      if (res !== er[i] || z !== (er[i] == 16'h0) || ov !== eo[i]) begin
        tests_failed++;
        $display("FAIL directed_result op=%h got res=%h z=%b ov=%b want res=%h z=%b ov=%b",
                 ops[i], res, z, ov, er[i], (er[i] == 16'h0), eo[i]);
      end
      tests_run++;
      if (lat !== el[i] || !bok || !pok) begin
        tests_failed++;
        $display("FAIL directed_timing op=%h got lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                 ops[i], lat, bok, pok, el[i]);
      end
    end
  endtask

  task automatic test_mul_disabled();
    int lat;
    bit bok, pok;
    logic [15:0] res;
    logic z, ov;
    issue(1, 4'h9, 16'h0D, 16'h0B, lat, bok, pok, res, z, ov);
    tests_run++;
    if (res !== 16'h0 || z !== 1'b1 || lat !== 0 || !bok || !pok) begin
      tests_failed++;
      $display("FAIL mul_disabled got res=%h z=%b lat=%0d busy_ok=%b want 00 1 0 1",
               res, z, lat, bok);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    sel = 4'h9; d1_8 = 8'h0D; d2_8 = 8'h0B; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        @(negedge clk);
        sel = 4'h1; d1_8 = 8'h01; d2_8 = 8'h01; start8 = 1'b1;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      lat++;
    end
    tests_run++;
    if (lat !== 8 || res8 !== 8'h8F) begin
      tests_failed++;
      $display("FAIL start_while_busy got lat=%0d res=%h want 8 8f", lat, res8);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 8'h8F) begin
      tests_failed++;
      $display("FAIL no_queued_op got done=%b busy=%b res=%h want 0 0 8f", done8, busy8, res8);
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    bit bok, pok;
    logic [15:0] res;
    logic z, ov;
    @(negedge clk);
    sel = 4'h9; d1_8 = 8'h0D; d2_8 = 8'h0B; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, res8, zero8, ovf8} !== 12'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_mul got busy=%b done=%b res=%h zero=%b ovf=%b want all 0",
               busy8, done8, res8, zero8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done8 !== 1'b0 || busy8 !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done got %0d active cycles want 0", seen);
    end
    issue(0, 4'h1, 16'h02, 16'h03, lat, bok, pok, res, z, ov);
    tests_run++;
    if (res !== 16'h05 || lat !== 0 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_after_reset got res=%h lat=%0d z=%b want 05 0 0", res, lat, z);
    end
  endtask

  task automatic test_width16();
    int lat;
    bit bok, pok;
    logic [15:0] res;
    logic z, ov;
    issue(2, 4'h1, 16'h7FFF, 16'h0001, lat, bok, pok, res, z, ov);
    tests_run++;
    if (res !== 16'h8000 || ov !== 1'b1 || lat !== 0) begin
      tests_failed++;
      $display("FAIL w16_add got res=%h ov=%b lat=%0d want 8000 1 0", res, ov, lat);
    end
    issue(2, 4'h5, 16'h0001, 16'h000F, lat, bok, pok, res, z, ov);
    tests_run++;
    if (res !== 16'h8000 || lat !== 15 || !bok || !pok) begin
      tests_failed++;
      $display("FAIL w16_sll15 got res=%h lat=%0d busy_ok=%b pulse_ok=%b want 8000 15 1 1",
               res, lat, bok, pok);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    sel = 4'h1; d1_8 = 8'h10; d2_8 = 8'h20; start8 = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (done8 !== 1'b1 || res8 !== 8'h30) begin
      tests_failed++;
      $display("FAIL b2b_first got done=%b res=%h want 1 30", done8, res8);
    end
    @(negedge clk);
    sel = 4'h4;
    @(posedge clk);
    #1;
    tests_run++;
    if (done8 !== 1'b1 || res8 !== 8'hF0 || ovf8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second got done=%b res=%h ovf=%b want 1 f0 0", done8, res8, ovf8);
    end
    @(negedge clk);
    sel = 4'h8; d1_8 = 8'h03; d2_8 = 8'h02;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_third_accept got busy=%b done=%b want 1 0", busy8, done8);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || res8 !== 8'hC0) begin
      tests_failed++;
      $display("FAIL b2b_third_done got done=%b busy=%b res=%h want 1 0 c0", done8, busy8, res8);
    end
  endtask

  task automatic test_random(input int u, input int count);
    int w, lat, elat;
    bit men, bok, pok, eov;
    longint a, b, mask, r;
    logic [31:0] rnd;
    logic [3:0] op;
    logic [15:0] res, er;
    logic z, ov;
    w    = (u == 2) ? 16 : 8;
    men  = (u != 1);
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < count; i++) begin
      rnd = $urandom;
      a   = longint'(rnd[15:0]) & mask;
      b   = longint'(rnd[31:16]) & mask;
      op  = 4'($urandom_range(0, 15));
      model(w, men, op, a, b, r, eov, elat);
      er = r[15:0];
      issue(u, op, a[15:0], b[15:0], lat, bok, pok, res, z, ov);
      tests_run++;
      if (res !== er || z !== (er == 16'h0) || ov !== eov) begin
        tests_failed++;
        $display("FAIL rand_result u=%0d op=%h a=%h b=%h got res=%h z=%b ov=%b want %h %b %b",
                 u, op, a[15:0], b[15:0], res, z, ov, er, (er == 16'h0), eov);
      end
      tests_run++;
      if (lat !== elat || !bok || !pok) begin
        tests_failed++;
        $display("FAIL rand_timing u=%0d op=%h b=%h got lat=%0d busy_ok=%b pulse_ok=%b want %0d 1 1",
                 u, op, b[15:0], lat, bok, pok, elat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_mul_disabled();
    test_start_ignored();
    test_reset_mid();
    test_width16();
    test_back_to_back();
    test_random(0, 60);
    test_random(1, 20);
    test_random(2, 30);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
